nmcu_host_bridge: RTL and testbench

- Host-side front end sitting directly upstream of the nmcu chiplet top.
- Buffers CPU instructions in an issue FIFO and drives them into the nmcu instruction valid/ready port.
- Tracks in-flight instructions and buffers nmcu responses in a response FIFO for the host.
- Throttles issue so every in-flight instruction is guaranteed a response slot; provides a flush/drain sequence.

---
 rtl/nmcu_host_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_nmcu_host_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_host_bridge.sv
// Host-side bridge in front of the nmcu chiplet: issue FIFO, in-flight tracking, response FIFO
// and a flush/drain sequence. Define NMCU_BRIDGE_PERF_EN to build the saturating perf counters.

package instr_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [23:0] data;
  } nmcu_cpu_resp_t;
endpackage

module nmcu_host_bridge
  import instr_pkg::*;
#(
  parameter int unsigned INSTR_DEPTH     = 4,
  parameter int unsigned RESP_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       host_instr_valid_i,
  input  logic [$bits(instr_pkg::instruction_t)-1:0] host_instr_i,
  output logic                                       host_instr_ready_o,
  output logic                                       nmcu_instr_valid_o,
  output logic [$bits(instr_pkg::instruction_t)-1:0] nmcu_instr_o,
  input  logic                                       nmcu_instr_ready_i,
  input  logic                                       nmcu_resp_valid_i,
  input  logic [$bits(instr_pkg::nmcu_cpu_resp_t)-1:0] nmcu_resp_i,
  output logic                                       nmcu_resp_ready_o,
  output logic                                       host_resp_valid_o,
  output logic [$bits(instr_pkg::nmcu_cpu_resp_t)-1:0] host_resp_o,
  input  logic                                       host_resp_ready_i,
  input  logic                                       flush_i,
  output logic                                       flush_done_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
  output logic                                       resp_err_o,
  input  logic                                       clear_err_i,
  output logic [CNT_WIDTH-1:0]                       perf_issued_o,
  output logic [CNT_WIDTH-1:0]                       perf_retired_o,
  output logic [CNT_WIDTH-1:0]                       perf_stall_o
);

  localparam int unsigned IW  = $bits(instruction_t);
  localparam int unsigned RW  = $bits(nmcu_cpu_resp_t);
  localparam int unsigned IAW = $clog2(INSTR_DEPTH);
  localparam int unsigned RAW = $clog2(RESP_DEPTH);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StRun, StFlushDrain, StFlushDone} state_e;

  state_e         state_q;
  logic           flush_done_q;
  logic           resp_err_q;
  logic [OW-1:0]  outstanding_q, outstanding_d;

  logic           run;
  logic           flush_accept;
  logic           issue_hs;
  logic           retire_hs;
  logic [31:0]    resp_fill;

  // Issue FIFO
  logic [IW-1:0]  iq_mem [INSTR_DEPTH];
  logic [IAW:0]   iq_wptr_q, iq_rptr_q;
  logic           iq_empty, iq_full, iq_push;

  // Response FIFO
  logic [RW-1:0]  rq_mem [RESP_DEPTH];
  logic [RAW:0]   rq_wptr_q, rq_rptr_q;
  logic [RAW:0]   rq_count;
  logic           rq_empty, rq_full, rq_pop;

  assign run          = (state_q == StRun);
  assign flush_accept = run && flush_i;

  assign iq_empty = (iq_wptr_q == iq_rptr_q);
  assign iq_full  = (iq_wptr_q[IAW] != iq_rptr_q[IAW]) &&
                    (iq_wptr_q[IAW-1:0] == iq_rptr_q[IAW-1:0]);
  assign rq_empty = (rq_wptr_q == rq_rptr_q);
  assign rq_full  = (rq_wptr_q[RAW] != rq_rptr_q[RAW]) &&
                    (rq_wptr_q[RAW-1:0] == rq_rptr_q[RAW-1:0]);
  assign rq_count = rq_wptr_q - rq_rptr_q;

  assign host_instr_ready_o = !iq_full && run;
  assign iq_push            = host_instr_valid_i && host_instr_ready_o;

  // Reserve a response slot for every in-flight instruction before issuing another.
  assign resp_fill          = 32'(outstanding_q) + 32'(rq_count);
  assign nmcu_instr_valid_o = !iq_empty && run && (32'(outstanding_q) < MAX_OUTSTANDING) &&
                              (resp_fill < RESP_DEPTH);
  assign nmcu_instr_o       = iq_mem[iq_rptr_q[IAW-1:0]];
  assign issue_hs           = nmcu_instr_valid_o && nmcu_instr_ready_i;

  assign nmcu_resp_ready_o  = !rq_full;
  assign retire_hs          = nmcu_resp_valid_i && nmcu_resp_ready_o;
  assign host_resp_valid_o  = !rq_empty;
  assign host_resp_o        = rq_mem[rq_rptr_q[RAW-1:0]];
  assign rq_pop             = host_resp_valid_o && host_resp_ready_i;

  assign outstanding_o = outstanding_q;
  assign flush_done_o  = flush_done_q;
  assign resp_err_o    = resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_wptr_q <= '0;
      iq_rptr_q <= '0;
    end else if (flush_accept) begin
      // Unissued entries are dropped as the bridge leaves RUN.
      iq_wptr_q <= '0;
      iq_rptr_q <= '0;
    end else begin
      if (iq_push)  iq_wptr_q <= iq_wptr_q + 1'b1;
      if (issue_hs) iq_rptr_q <= iq_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (iq_push) iq_mem[iq_wptr_q[IAW-1:0]] <= host_instr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_wptr_q <= '0;
      rq_rptr_q <= '0;
    end else begin
      if (retire_hs) rq_wptr_q <= rq_wptr_q + 1'b1;
      if (rq_pop)    rq_rptr_q <= rq_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (retire_hs) rq_mem[rq_wptr_q[RAW-1:0]] <= nmcu_resp_i;
  end

  // A response with nothing in flight is buffered but never decrements below zero.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_hs) outstanding_d = outstanding_d + OW'(1);
    if (retire_hs && (outstanding_q != '0)) outstanding_d = outstanding_d - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (retire_hs && (outstanding_q == '0)) resp_err_q <= 1'b1;
      else if (clear_err_i)                   resp_err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (flush_i) state_q <= StFlushDrain;
        end
        StFlushDrain: begin
          if (outstanding_q == '0) begin
            state_q      <= StFlushDone;
            flush_done_q <= 1'b1;
          end
        end
        StFlushDone: state_q <= StRun;
        default:     state_q <= StRun;
      endcase
    end
  end

`ifdef NMCU_BRIDGE_PERF_EN
  logic [CNT_WIDTH-1:0] perf_issued_q, perf_retired_q, perf_stall_q;
  logic                 stall;

  assign stall = !iq_empty && run && !issue_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q  <= '0;
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (issue_hs && (perf_issued_q != '1))   perf_issued_q  <= perf_issued_q + 1'b1;
      if (retire_hs && (perf_retired_q != '1)) perf_retired_q <= perf_retired_q + 1'b1;
      if (stall && (perf_stall_q != '1))       perf_stall_q   <= perf_stall_q + 1'b1;
    end
  end

  assign perf_issued_o  = perf_issued_q;
  assign perf_retired_o = perf_retired_q;
  assign perf_stall_o   = perf_stall_q;
`else
  assign perf_issued_o  = '0;
  assign perf_retired_o = '0;
  assign perf_stall_o   = '0;
`endif

endmodule

// File: tb/tb_nmcu_host_bridge.sv
// Directed self-checking bench for nmcu_host_bridge (default parameters).

module tb_nmcu_host_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_instr_valid_i = 1'b0;
  logic [31:0] host_instr_i = '0;
  logic        host_instr_ready_o;
  logic        nmcu_instr_valid_o;
  logic [31:0] nmcu_instr_o;
  logic        nmcu_instr_ready_i = 1'b0;
  logic        nmcu_resp_valid_i = 1'b0;
  logic [31:0] nmcu_resp_i = '0;
  logic        nmcu_resp_ready_o;
  logic        host_resp_valid_o;
  logic [31:0] host_resp_o;
  logic        host_resp_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        flush_done_o;
  logic [2:0]  outstanding_o;
  logic        resp_err_o;
  logic        clear_err_i = 1'b0;
  logic [31:0] perf_issued_o, perf_retired_o, perf_stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] instr_tab [6];
  logic [31:0] resp_tab  [4];

  always #5 clk = ~clk;

  nmcu_host_bridge dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .host_instr_valid_i (host_instr_valid_i),
    .host_instr_i       (host_instr_i),
    .host_instr_ready_o (host_instr_ready_o),
    .nmcu_instr_valid_o (nmcu_instr_valid_o),
    .nmcu_instr_o       (nmcu_instr_o),
    .nmcu_instr_ready_i (nmcu_instr_ready_i),
    .nmcu_resp_valid_i  (nmcu_resp_valid_i),
    .nmcu_resp_i        (nmcu_resp_i),
    .nmcu_resp_ready_o  (nmcu_resp_ready_o),
    .host_resp_valid_o  (host_resp_valid_o),
    .host_resp_o        (host_resp_o),
    .host_resp_ready_i  (host_resp_ready_i),
    .flush_i            (flush_i),
    .flush_done_o       (flush_done_o),
    .outstanding_o      (outstanding_o),
    .resp_err_o         (resp_err_o),
    .clear_err_i        (clear_err_i),
    .perf_issued_o      (perf_issued_o),
    .perf_retired_o     (perf_retired_o),
    .perf_stall_o       (perf_stall_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    host_instr_valid_i = 1'b0;
    nmcu_instr_ready_i = 1'b0;
    nmcu_resp_valid_i  = 1'b0;
    host_resp_ready_i  = 1'b0;
    flush_i            = 1'b0;
    clear_err_i        = 1'b0;
    rst_n              = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    instr_tab[0] = 32'hA1000001; instr_tab[1] = 32'hB2000002; instr_tab[2] = 32'hC3000003;
    instr_tab[3] = 32'hD4000004; instr_tab[4] = 32'hE5000005; instr_tab[5] = 32'hF6000006;
    resp_tab[0]  = 32'h11111111; resp_tab[1]  = 32'h22222222;
    resp_tab[2]  = 32'h33333333; resp_tab[3]  = 32'h44444444;

    // Reset state
    do_reset();
    check_eq("rst_host_ready", host_instr_ready_o, 1);
    check_eq("rst_nmcu_valid", nmcu_instr_valid_o, 0);
    check_eq("rst_resp_ready", nmcu_resp_ready_o, 1);
    check_eq("rst_host_rvalid", host_resp_valid_o, 0);
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_flush_done", flush_done_o, 0);
    check_eq("rst_err", resp_err_o, 0);
    check_eq("rst_perf_issued", perf_issued_o, 0);

    // In-order issue with nmcu always ready
    nmcu_instr_ready_i = 1'b1;
    host_instr_valid_i = 1'b1;
    host_instr_i = instr_tab[0];
    step();
    check_eq("s1_valid_a", nmcu_instr_valid_o, 1);
    check_eq("s1_instr_a", nmcu_instr_o, instr_tab[0]);
    host_instr_i = instr_tab[1];
    step();
    check_eq("s1_instr_b", nmcu_instr_o, instr_tab[1]);
    check_eq("s1_out1", outstanding_o, 1);
    host_instr_i = instr_tab[2];
    step();
    check_eq("s1_instr_c", nmcu_instr_o, instr_tab[2]);
    check_eq("s1_out2", outstanding_o, 2);
    host_instr_valid_i = 1'b0;
    step();
    check_eq("s1_valid_idle", nmcu_instr_valid_o, 0);
    check_eq("s1_out3", outstanding_o, 3);
`ifdef NMCU_BRIDGE_PERF_EN
    check_eq("s1_perf_issued", perf_issued_o, 3);
    check_eq("s1_perf_retired", perf_retired_o, 0);
    check_eq("s1_perf_stall", perf_stall_o, 0);
`else
    check_eq("s1_perf_issued_off", perf_issued_o, 0);
    check_eq("s1_perf_stall_off", perf_stall_o, 0);
`endif

    // Issue FIFO fills while nmcu stalls
    do_reset();
    host_instr_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_instr_i = instr_tab[i];
      step();
      if (i == 2) check_eq("s2_ready_3", host_instr_ready_o, 1);
    end
    check_eq("s2_ready_full", host_instr_ready_o, 0);
    check_eq("s2_valid", nmcu_instr_valid_o, 1);
    host_instr_i = instr_tab[4];
    step();
    step();
    check_eq("s2_ready_held", host_instr_ready_o, 0);
    check_eq("s2_head_stable", nmcu_instr_o, instr_tab[0]);
    nmcu_instr_ready_i = 1'b1;
    step();
    host_instr_valid_i = 1'b0;
    nmcu_instr_ready_i = 1'b0;
    check_eq("s2_out1", outstanding_o, 1);
    check_eq("s2_head_b", nmcu_instr_o, instr_tab[1]);
    check_eq("s2_ready_again", host_instr_ready_o, 1);

    // MAX_OUTSTANDING throttle
    do_reset();
    nmcu_instr_ready_i = 1'b1;
    host_resp_ready_i  = 1'b1;
    host_instr_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_instr_i = instr_tab[i];
      step();
    end
    host_instr_valid_i = 1'b0;
    check_eq("s3_out4", outstanding_o, 4);
    check_eq("s3_valid_gated", nmcu_instr_valid_o, 0);
    check_eq("s3_head_e", nmcu_instr_o, instr_tab[4]);
    nmcu_resp_valid_i = 1'b1;
    nmcu_resp_i = resp_tab[0];
    step();
    nmcu_resp_valid_i = 1'b0;
    check_eq("s3_out3", outstanding_o, 3);
    check_eq("s3_valid_slotgate", nmcu_instr_valid_o, 0);
    check_eq("s3_host_rvalid", host_resp_valid_o, 1);
    check_eq("s3_host_resp", host_resp_o, resp_tab[0]);
    step();
    check_eq("s3_rq_drained", host_resp_valid_o, 0);
    check_eq("s3_valid_e", nmcu_instr_valid_o, 1);
    check_eq("s3_instr_e", nmcu_instr_o, instr_tab[4]);
    step();
    check_eq("s3_out4_again", outstanding_o, 4);
    check_eq("s3_head_f", nmcu_instr_o, instr_tab[5]);

    // Response FIFO backpressure and in-order drain
    do_reset();
    nmcu_instr_ready_i = 1'b1;
    host_instr_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_instr_i = instr_tab[i];
      step();
    end
    host_instr_valid_i = 1'b0;
    step();
    check_eq("s4_out4", outstanding_o, 4);
    host_instr_valid_i = 1'b1;
    host_instr_i = instr_tab[4];
    step();
    host_instr_valid_i = 1'b0;
    nmcu_resp_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nmcu_resp_i = resp_tab[i];
      step();
    end
    nmcu_resp_valid_i = 1'b0;
    check_eq("s4_resp_ready_full", nmcu_resp_ready_o, 0);
    check_eq("s4_out0", outstanding_o, 0);
    check_eq("s4_issue_gated", nmcu_instr_valid_o, 0);
    check_eq("s4_host_rvalid", host_resp_valid_o, 1);
    nmcu_instr_ready_i = 1'b0;
    host_resp_ready_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("s4_resp%0d", i), host_resp_o, resp_tab[i]);
      step();
    end
    host_resp_ready_i = 1'b0;
    check_eq("s4_rq_empty", host_resp_valid_o, 0);
    check_eq("s4_resp_ready", nmcu_resp_ready_o, 1);
    check_eq("s4_issue_open", nmcu_instr_valid_o, 1);

    // Flush with two in flight and two queued
    do_reset();
    nmcu_instr_ready_i = 1'b1;
    host_resp_ready_i  = 1'b1;
    host_instr_valid_i = 1'b1;
    host_instr_i = instr_tab[0];
    step();
    host_instr_i = instr_tab[1];
    step();
    host_instr_valid_i = 1'b0;
    step();
    nmcu_instr_ready_i = 1'b0;
    host_instr_valid_i = 1'b1;
    host_instr_i = instr_tab[2];
    step();
    host_instr_i = instr_tab[3];
    step();
    host_instr_valid_i = 1'b0;
    check_eq("s5_out2", outstanding_o, 2);
    check_eq("s5_queued_valid", nmcu_instr_valid_o, 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    nmcu_instr_ready_i = 1'b1;
    check_eq("s5_drain_ready", host_instr_ready_o, 0);
    check_eq("s5_drain_valid", nmcu_instr_valid_o, 0);
    nmcu_resp_valid_i = 1'b1;
    nmcu_resp_i = resp_tab[0];
    step();
    nmcu_resp_i = resp_tab[1];
    step();
    nmcu_resp_valid_i = 1'b0;
    check_eq("s5_out0", outstanding_o, 0);
    check_eq("s5_done_early", flush_done_o, 0);
    step();
    check_eq("s5_done_pulse", flush_done_o, 1);
    check_eq("s5_done_ready", host_instr_ready_o, 0);
    step();
    check_eq("s5_done_clear", flush_done_o, 0);
    check_eq("s5_ready_back", host_instr_ready_o, 1);
    check_eq("s5_queue_dropped", nmcu_instr_valid_o, 0);

    // Unexpected response sets a sticky error
    do_reset();
    nmcu_resp_valid_i = 1'b1;
    nmcu_resp_i = resp_tab[2];
    step();
    nmcu_resp_valid_i = 1'b0;
    check_eq("s6_err_set", resp_err_o, 1);
    check_eq("s6_out_zero", outstanding_o, 0);
    check_eq("s6_buffered", host_resp_o, resp_tab[2]);
    step();
    step();
    check_eq("s6_err_sticky", resp_err_o, 1);
    clear_err_i = 1'b1;
    step();
    clear_err_i = 1'b0;
    check_eq("s6_err_cleared", resp_err_o, 0);
    clear_err_i = 1'b1;
    nmcu_resp_valid_i = 1'b1;
    nmcu_resp_i = resp_tab[3];
    step();
    clear_err_i = 1'b0;
    nmcu_resp_valid_i = 1'b0;
    check_eq("s6_set_wins", resp_err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
